// File: rtl/sift_desc_pkg.sv
// Shared types and constants for the SIFT descriptor rotation scan logic.
package sift_desc_pkg;
  localparam int WIN_DIM     = 16;
  localparam int WIN_SAMPLES = WIN_DIM * WIN_DIM;
  localparam int ORI_W_DEF   = 6;
  localparam int WIN_LIM_DEF = 8;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  typedef logic signed [4:0] offset_t;
endpackage

// File: rtl/desc_out_reg.sv
// One-stage valid/ready output register for rotated descriptor samples.
module desc_out_reg
  import sift_desc_pkg::*;
#(
  parameter int WIN_LIM = WIN_LIM_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       load,
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  offset_t    dx,
  input  offset_t    dy,
  input  logic       last,
  input  logic       out_ready,
  output logic       adv,
  output logic       out_valid,
  output logic [3:0] out_row,
  output logic [3:0] out_col,
  output offset_t    out_dx,
  output offset_t    out_dy,
  output logic       out_inwin,
  output logic       out_last
);
  logic in_win;

  assign adv = !out_valid || out_ready;

  // Bounds are evaluated on the sign-extended offsets
  always_comb begin
    in_win = (int'(dx) >= -WIN_LIM) && (int'(dx) <= WIN_LIM - 1) &&
             (int'(dy) >= -WIN_LIM) && (int'(dy) <= WIN_LIM - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_dx    <= '0;
      out_dy    <= '0;
      out_inwin <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= load;
      if (load) begin
        out_row   <= row;
        out_col   <= col;
        out_dx    <= dx;
        out_dy    <= dy;
        out_inwin <= in_win;
        out_last  <= last;
      end
    end
  end
endmodule

// File: rtl/desc_rot_scan_ctrl.sv
// Raster-scan sequencer driving the dx/dy rotation ROM pair for one keypoint.
module desc_rot_scan_ctrl
  import sift_desc_pkg::*;
#(
  parameter int ORI_W   = ORI_W_DEF,
  parameter int WIN_LIM = WIN_LIM_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ORI_W-1:0] ori_in,
  output logic [ORI_W-1:0] ori_sel,
  output logic [7:0]       rom_addr,
  input  logic [4:0]       rom_dx,
  input  logic [4:0]       rom_dy,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_row,
  output logic [3:0]       out_col,
  output logic [4:0]       out_dx,
  output logic [4:0]       out_dy,
  output logic             out_inwin,
  output logic             out_last
);
  localparam logic [7:0] LAST_ADDR = 8'(WIN_SAMPLES - 1);

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic [ORI_W-1:0] ori_n;
  logic             busy_n, done_n;
  logic             adv, load, flush;

  assign rom_addr = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ori_sel <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ori_sel <= ori_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ori_n   = ori_sel;
    busy_n  = busy;
    done_n  = 1'b0;
    load    = 1'b0;
    flush   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          ori_n   = ori_in;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          flush   = 1'b1;
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (adv) begin
          load = 1'b1;
          // Address stays at the final sample while the last beat drains
          if (cnt == LAST_ADDR) state_n = DRAIN;
          else                  cnt_n   = cnt + 8'd1;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (out_ready) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  desc_out_reg #(
    .WIN_LIM(WIN_LIM)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .load     (load),
    .row      (cnt[7:4]),
    .col      (cnt[3:0]),
    .dx       (rom_dx),
    .dy       (rom_dy),
    .last     (cnt == LAST_ADDR),
    .out_ready(out_ready),
    .adv      (adv),
    .out_valid(out_valid),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_dx   (out_dx),
    .out_dy   (out_dy),
    .out_inwin(out_inwin),
    .out_last (out_last)
  );
endmodule

// File: tb/tb_desc_rot_scan_ctrl.sv
// Self-checking bench for desc_rot_scan_ctrl with a table-based ROM model.
module tb_desc_rot_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start, abort, out_ready;
  logic [5:0] ori_in, ori_sel;
  logic [7:0] rom_addr;
  logic [4:0] rom_dx, rom_dy;
  logic       busy, done, out_valid, out_inwin, out_last;
  logic [3:0] out_row, out_col;
  logic [4:0] out_dx, out_dy;

  logic [4:0] dx_tab [256];
  logic [4:0] dy_tab [256];

  always #5 clk = ~clk;

  assign rom_dx = dx_tab[rom_addr];
  assign rom_dy = dy_tab[rom_addr];

  desc_rot_scan_ctrl #(
    .ORI_W  (6),
    .WIN_LIM(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ori_in(ori_in), .ori_sel(ori_sel), .rom_addr(rom_addr),
    .rom_dx(rom_dx), .rom_dy(rom_dy), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_col(out_col), .out_dx(out_dx), .out_dy(out_dy),
    .out_inwin(out_inwin), .out_last(out_last)
  );

  typedef struct {
    int         addr;
    logic [4:0] dx;
    logic [4:0] dy;
    logic       inwin;
  } vec_t;
  vec_t vecs [9];

  int         checks = 0, errors = 0;
  int         cyc, exp_idx, beats, done_cnt, first_valid, done_cyc;
  logic [7:0] prev_addr;
  logic       prev_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [4:0] v);
    return (v >= 5'd16) ? int'(v) - 32 : int'(v);
  endfunction

  // Expected beat k from raster order and the signed window bounds
  function automatic logic [19:0] model_beat(input int k);
    int   x, y;
    logic iw;
    x  = sx(dx_tab[k]);
    y  = sx(dy_tab[k]);
    iw = (x >= -8) && (x <= 7) && (y >= -8) && (y <= 7);
    return {4'(k / 16), 4'(k % 16), dx_tab[k], dy_tab[k], iw, (k == 255)};
  endfunction

  task automatic fill_tables();
    for (int i = 0; i < 256; i++) begin
      dx_tab[i] = 5'($urandom);
      dy_tab[i] = 5'($urandom);
    end
    foreach (vecs[i]) begin
      dx_tab[vecs[i].addr] = vecs[i].dx;
      dy_tab[vecs[i].addr] = vecs[i].dy;
    end
  endtask

  // Called at the negedge with inputs set; checks, then advances one cycle
  task automatic tick();
    if (out_valid) begin
      if (exp_idx > 255) check("extra_beat", 1, 0);
      else begin
        check("beat", {out_row, out_col, out_dx, out_dy, out_inwin, out_last},
              model_beat(exp_idx));
        if (out_ready)
          foreach (vecs[i])
            if (vecs[i].addr == exp_idx) begin
              check("vec_dx", out_dx, vecs[i].dx);
              check("vec_inwin", out_inwin, vecs[i].inwin);
            end
      end
      if (first_valid < 0) first_valid = cyc;
      if (out_ready) begin
        exp_idx++;
        beats++;
      end
    end
    if (busy && prev_busy)
      check("addr_step", (rom_addr == prev_addr) || (rom_addr == prev_addr + 8'd1), 1);
    prev_busy = busy;
    prev_addr = rom_addr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic begin_scan(input logic [5:0] ori);
    exp_idx = 0; beats = 0; done_cnt = 0; cyc = 0;
    first_valid = -1; done_cyc = -1;
    ori_in = ori; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ori_latch", ori_sel, ori);
    check("addr_first", rom_addr, 0);
  endtask

  // mode 0: ready high, 1: toggling, 2: random; inj: cycle for a stray start
  task automatic run_scan(input logic [5:0] ori, input int mode, input int inj, input int max);
    begin_scan(ori);
    while (done_cnt == 0 && cyc < max) begin
      start = (cyc == inj);
      if (cyc == inj) ori_in = 6'd5;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = 1'($urandom);
      endcase
      tick();
    end
    start = 1'b0;
    check("done_seen", done_cnt, 1);
    check("beat_count", beats, 256);
    check("busy_end", busy, 0);
    tick();
    check("done_once", done_cnt, 1);
  endtask

  initial begin
    vecs[0] = '{0,  5'h01, 5'h00, 1'b1};
    vecs[1] = '{1,  5'h00, 5'h00, 1'b1};
    vecs[2] = '{2,  5'h1f, 5'h00, 1'b1};
    vecs[3] = '{8,  5'h17, 5'h00, 1'b0};
    vecs[4] = '{12, 5'h18, 5'h00, 1'b1};
    vecs[5] = '{20, 5'h00, 5'h08, 1'b0};
    vecs[6] = '{21, 5'h07, 5'h18, 1'b1};
    vecs[7] = '{22, 5'h08, 5'h00, 1'b0};
    vecs[8] = '{23, 5'h00, 5'h17, 1'b0};
    fill_tables();
    prev_busy = 1'b0; prev_addr = '0;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; ori_in = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {ori_sel, rom_addr, out_row, out_col, out_dx, out_dy,
                         busy, done, out_valid, out_inwin, out_last}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic scan with timing
    run_scan(6'd14, 0, -1, 400);
    check("first_valid_cyc", first_valid, 2);
    check("done_cyc", done_cyc, 258);

    // Back-pressure, toggling and random
    fill_tables();
    run_scan(6'd14, 1, -1, 1000);
    fill_tables();
    run_scan(6'd33, 2, -1, 2000);

    // Start while busy
    run_scan(6'd14, 0, 40, 400);
    check("ori_hold", ori_sel, 14);

    // Start and abort together in IDLE
    start = 1'b1; abort = 1'b1; ori_in = 6'd9;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);
    check("idle_abort_valid", out_valid, 0);

    // Abort while stalled at beat 100
    begin_scan(6'd9);
    while (exp_idx < 100 && cyc < 400) tick();
    out_ready = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 1);
    check("abort_addr", rom_addr, 0);
    tick();
    check("abort_done_pulse", done, 0);
    fill_tables();
    run_scan(6'd3, 2, -1, 2000);

    // Asynchronous reset mid-scan
    begin_scan(6'd21);
    while (exp_idx < 50 && cyc < 400) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {ori_sel, rom_addr, out_row, out_col, out_dx, out_dy,
                          busy, done, out_valid, out_inwin, out_last}, 0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    rst_n = 1'b1;
    prev_busy = 1'b0;
    tick();
    check("midrst_idle_busy", busy, 0);
    run_scan(6'd7, 0, -1, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/desc_rot_scan_ctrl.md
Name: desc_rot_scan_ctrl

Overview:
- Sequencer for the SIFT descriptor rotation lookup ROMs. Each ROM is a combinational 8-bit-address, 5-bit two's-complement offset table.
- On start, latches the keypoint orientation index and walks all 256 window samples in raster order (address = {row[3:0], col[3:0]}), driving one shared address to the dx/dy ROM pair.
- Registers the rotated offsets and emits them to the descriptor histogram stage through a valid/ready handshake, with back-pressure and abort.

Parameters:
- ORI_W, 6, width of orientation index (supports up to 64 orientation tables).
- WIN_LIM, 8, in-window limit; sample is in-window when -WIN_LIM <= dx,dy <= WIN_LIM-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begin a scan (ignored unless IDLE).
- abort  in  1  single-cycle pulse; terminate scan.
- ori_in  in  ORI_W  orientation index, sampled with start.
- ori_sel  out  ORI_W  latched orientation; selects the ROM pair externally.
- rom_addr  out  8  address to dx and dy ROMs.
- rom_dx  in  5  signed dx from ROM (combinational on rom_addr).
- rom_dy  in  5  signed dy from ROM.
- busy  out  1  high from accepted start until scan ends.
- done  out  1  one-cycle pulse after last beat accepted or abort.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_row  out  4  sample row.
- out_col  out  4  sample column.
- out_dx  out  5  registered signed dx.
- out_dy  out  5  registered signed dy.
- out_inwin  out  1  dx and dy both within WIN_LIM bounds.
- out_last  out  1  beat is sample 255.

Behaviour:
- Reset (async, rst_n=0) values:
  - State = IDLE.
  - ori_sel, rom_addr, out_row, out_col, out_dx and out_dy = 0.
  - busy, done, out_valid, out_inwin and out_last = 0.
- FSM states:
  - IDLE: start → latch ori_in into ori_sel, rom_addr=0, busy=1, go to SCAN.
  - SCAN: counter cnt[7:0] drives rom_addr. Define adv = !out_valid || out_ready.
    - When adv is true: load the output stage from the ROM data at cnt (row=cnt[7:4], col=cnt[3:0], out_last = cnt==255), set out_valid=1, then cnt+1.
    - If cnt==255 on advance, go to DRAIN with rom_addr held at 255 (no wrap).
    - When adv is false: all state is held.
  - DRAIN: out_valid held until out_ready. On acceptance: out_valid=0, busy=0, done=1 for one cycle, go to IDLE.
- Timing:
  - Latency start → first out_valid = 2 cycles (cycle 1 latches, cycle 2 registers address 0 data).
  - Full throughput is 1 beat/cycle with out_ready held high: 256 beats, done at cycle 258 after start.
- Handshake rules:
  - While out_valid=1 and out_ready=0, all out_* fields are stable.
  - out_valid never drops without acceptance, except on abort.
- out_inwin is computed from the sign-extended ROM values at load time and registered with them.
- Simultaneous events:
  - start while busy is ignored, with no relatch of ori_sel.
  - start and abort together in IDLE: abort wins and start is ignored; done is not pulsed.
- Abort in SCAN or DRAIN:
  - Next cycle: out_valid=0, busy=0, done=1 for one cycle, state IDLE.
  - rom_addr returns to 0; a pending beat is discarded.
- Abort in IDLE: no effect.
- Reset mid-scan: immediate return to reset values; no done pulse.

Decomposition:
- Shared package `sift_desc_pkg`:
  - WIN_DIM=16 and WIN_SAMPLES=256.
  - ORI_W and WIN_LIM defaults.
  - State enum {IDLE, SCAN, DRAIN}.
  - Offset type as signed 5-bit.
- One natural sub-module: `desc_out_reg`, a one-stage valid/ready output register holding row/col/dx/dy/inwin/last with its adv logic. The FSM and address counter stay in the top module.

Test Plan:
- Basic scan: reset, start with ori_in=14, out_ready=1, using a bench ROM model where dx(addr 0)=5'h01, dx(addr 1)=5'h00, dx(addr 2)=5'h1f. Required response: ori_sel=14; first beat at cycle 2 with row=0, col=0, dx=+1; beat 2 dx=0; beat 3 dx=-1; 256 beats; out_last only on row=15, col=15; done at cycle 258.
- Back-pressure: toggle out_ready 0/1 every cycle → exactly 256 beats, each accepted once, fields stable while stalled, rom_addr sequence monotonic with no skips.
- In-window flag: model ROM returns dx=5'h17 (-9) at addr 8 → out_inwin=0; dx=5'h18 (-8) at addr 12 → out_inwin=1; dy=5'h08 → out_inwin=0.
- Abort: abort at beat 100 with out_ready=0 → next cycle out_valid=0, busy=0, done pulse; then start with ori_in=3 → fresh scan from addr 0 with ori_sel=3.
- Start while busy: pulse start with ori_in=5 during SCAN of ori 14 → ori_sel stays 14, beat count 256, single done pulse.
- Reset mid-scan: deassert rst_n asynchronously at beat 50 → all outputs 0 immediately, no done; after release, IDLE accepts a new start.
